// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the execute pipe (A)
// and the multi-cycle unit (B), staging the winning write for one cycle before issue.
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic [AW-1:0] busy_addr,
    output logic          last_b
);
    logic          out_valid;
    logic          last;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          grant_a;
    logic          grant_b;

    // last==1 means B won most recently, so A takes the next tie
    always_comb begin
        grant_a   = rst & ~hold & a_valid & (~b_valid | FIXED_PRIO | last);
        grant_b   = rst & ~hold & b_valid & ~grant_a;
        a_ready   = grant_a;
        b_ready   = grant_b;
        we        = rst & out_valid & ~hold & (out_addr != '0);
        waddr     = rst ? out_addr : '0;
        wdata     = rst ? out_data : '0;
        busy      = rst & out_valid;
        busy_addr = busy ? out_addr : '0;
        last_b    = last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            last      <= 1'b1;
        end else if (!hold) begin
            out_valid <= grant_a | grant_b;
            if (grant_a | grant_b) begin
                out_addr <= grant_a ? a_addr : b_addr;
                out_data <= grant_a ? a_data : b_data;
                last     <= grant_b;
            end
        end
    end
endmodule
